// File: rtl/period_tick_generator_if.sv
// Bundles the period condition input and the derived timebase outputs of period_tick_generator.
// Optional cond_ack signal is present only when PTG_COND_ACK_EN is defined.
interface period_tick_generator_if #(
    parameter int unsigned CW = 32
);
    logic          enable;
    logic [CW-1:0] condition;
    logic          clk_out;
    logic          full_tick;
    logic          half_tick;
    logic [CW-1:0] cycle_cnt;
    logic [CW-1:0] cond_active;
    logic          running;
`ifdef PTG_COND_ACK_EN
    logic          cond_ack;
`endif

    // master drives the condition; slave is the tick generator itself
    modport master (
`ifdef PTG_COND_ACK_EN
        input  cond_ack,
`endif
        output enable,
        output condition,
        input  clk_out,
        input  full_tick,
        input  half_tick,
        input  cycle_cnt,
        input  cond_active,
        input  running
    );

    modport slave (
`ifdef PTG_COND_ACK_EN
        output cond_ack,
`endif
        input  enable,
        input  condition,
        output clk_out,
        output full_tick,
        output half_tick,
        output cycle_cnt,
        output cond_active,
        output running
    );
endinterface

// File: rtl/period_tick_generator.sv
// Free-running period counter producing a 50%-duty data clock plus full/half period ticks.
// Define PTG_COND_ACK_EN to add the cond_ack pulse output on the interface.
module period_tick_generator #(
    parameter int unsigned CW         = 32,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input logic                    clk,
    input logic                    reset,
    period_tick_generator_if.slave bus
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cond_q, cond_d;
    logic          running_q, running_d;
    logic          clk_out_q, clk_out_d;
    logic          full_q, full_d;
    logic          half_q, half_d;
    logic          boundary;
    logic [CW-1:0] high_len;

    // A new condition is only taken while stopped or on the last cycle of a period.
    assign boundary = !running_q || (cnt_q == cond_q - CW'(1));
    assign high_len = cond_d - (cond_d >> 1);

    always_comb begin
        cond_d    = cond_q;
        cnt_d     = '0;
        running_d = 1'b0;
        if (!bus.enable) begin
            cond_d = bus.condition;
        end else if (boundary) begin
            cond_d    = bus.condition;
            running_d = (bus.condition != '0);
        end else begin
            cnt_d     = cnt_q + CW'(1);
            running_d = 1'b1;
        end
    end

    always_comb begin
        clk_out_d = IDLE_LEVEL;
        full_d    = 1'b0;
        half_d    = 1'b0;
        if (running_d) begin
            clk_out_d = (cnt_d < high_len);
            full_d    = (cnt_d == cond_d - CW'(1));
            half_d    = (cond_d >= CW'(2)) && (cnt_d == high_len - CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            cond_q    <= '0;
            running_q <= 1'b0;
            clk_out_q <= IDLE_LEVEL;
            full_q    <= 1'b0;
            half_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cond_q    <= cond_d;
            running_q <= running_d;
            clk_out_q <= clk_out_d;
            full_q    <= full_d;
            half_q    <= half_d;
        end
    end

`ifdef PTG_COND_ACK_EN
    logic cond_ack_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cond_ack_q <= 1'b0;
        end else begin
            cond_ack_q <= (cond_d != cond_q);
        end
    end

    assign bus.cond_ack = cond_ack_q;
`endif

    assign bus.cycle_cnt   = cnt_q;
    assign bus.cond_active = cond_q;
    assign bus.running     = running_q;
    assign bus.clk_out     = clk_out_q;
    assign bus.full_tick   = full_q;
    assign bus.half_tick   = half_q;
endmodule

// File: tb/tb_period_tick_generator.sv
// Directed bench for period_tick_generator: a period-position model checked every cycle,
// plus literal sequences for the hand-worked cases.
module tb_period_tick_generator;
    localparam int unsigned CW = 32;
    localparam logic IDLE_LEVEL = 1'b0;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;
    logic chk_on  = 1'b0;

    // model: current period length, position within it, generating flag
    longint unsigned m_cond = 0;
    longint unsigned m_pos  = 0;
    bit              m_run  = 0;
    bit              m_ack  = 0;

    period_tick_generator_if #(.CW(CW)) bus ();

    period_tick_generator #(
        .CW        (CW),
        .IDLE_LEVEL(IDLE_LEVEL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_cond <= 0;
            m_pos  <= 0;
            m_run  <= 0;
            m_ack  <= 0;
        end else if (!bus.enable || !m_run || m_pos == m_cond - 1) begin
            m_ack  <= (longint'(bus.condition) != m_cond);
            m_cond <= longint'(bus.condition);
            m_pos  <= 0;
            m_run  <= bus.enable && (bus.condition != 0);
        end else begin
            m_ack  <= 0;
            m_pos  <= m_pos + 1;
        end
    end

    // High phase is the first ceil(C/2) positions of the period.
    always @(negedge clk) begin
        if (chk_on) begin
            check("model_running", bus.running, m_run);
            check("model_cycle_cnt", bus.cycle_cnt, m_pos);
            check("model_cond_active", bus.cond_active, m_cond);
            check("model_clk_out", bus.clk_out,
                  m_run ? (m_pos < (m_cond + 1) / 2) : IDLE_LEVEL);
            check("model_full_tick", bus.full_tick, m_run && (m_pos == m_cond - 1));
            check("model_half_tick", bus.half_tick,
                  m_run && m_cond >= 2 && (m_pos == (m_cond + 1) / 2 - 1));
`ifdef PTG_COND_ACK_EN
            check("model_cond_ack", bus.cond_ack, m_ack);
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic collect(input int n, output logic [15:0] vc, output logic [15:0] vh,
                           output logic [15:0] vf);
        vc = '0; vh = '0; vf = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vc = {vc[14:0], bus.clk_out};
            vh = {vh[14:0], bus.half_tick};
            vf = {vf[14:0], bus.full_tick};
        end
    endtask

    logic [15:0] vc, vh, vf;

    initial begin
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.condition = '0;
        @(posedge clk);
        @(negedge clk);
        chk_on = 1'b1;
        tick(1);
        check("reset_clk_out", bus.clk_out, 0);
        check("reset_running", bus.running, 0);
        check("reset_cnt", bus.cycle_cnt, 0);
        check("reset_cond", bus.cond_active, 0);

        // C=4 straight out of reset
        reset = 1'b0; bus.enable = 1'b1; bus.condition = 32'd4;
        collect(8, vc, vh, vf);
        check("c4_clk_seq", vc, 16'b1100_1100);
        check("c4_half_seq", vh, 16'b0100_0100);
        check("c4_full_seq", vf, 16'b0001_0001);

        // C=5, odd: high phase one cycle longer
        bus.enable = 1'b0; bus.condition = 32'd5;
        tick(1);
        check("stopped_running", bus.running, 0);
        bus.enable = 1'b1;
        collect(10, vc, vh, vf);
        check("c5_clk_seq", vc, 16'b11100_11100);
        check("c5_half_seq", vh, 16'b00100_00100);
        check("c5_full_seq", vf, 16'b00001_00001);

        // mid-period changes held off; only the value at the boundary is taken
        bus.enable = 1'b0; bus.condition = 32'd4;
        tick(1);
        bus.enable = 1'b1;
        tick(1);
        bus.condition = 32'd7;
        tick(1);
        bus.condition = 32'd6;
        collect(10, vc, vh, vf);
        check("c4to6_clk_seq", vc, 16'b0011100011);
        check("c4to6_cond", bus.cond_active, 6);

        // C=0 stays stopped, C=1 ticks every cycle
        bus.enable = 1'b0; bus.condition = 32'd0;
        tick(1);
        bus.enable = 1'b1;
        tick(2);
        check("c0_running", bus.running, 0);
        check("c0_clk_out", bus.clk_out, IDLE_LEVEL);
        bus.condition = 32'd1;
        collect(4, vc, vh, vf);
        check("c1_clk_seq", vc, 16'b1111);
        check("c1_full_seq", vf, 16'b1111);
        check("c1_half_seq", vh, 16'b0000);

        // reset mid-period discards the partial period
        bus.enable = 1'b0; bus.condition = 32'd8;
        tick(1);
        bus.enable = 1'b1;
        tick(3);
        check("c8_cnt_before_reset", bus.cycle_cnt, 2);
        reset = 1'b1;
        tick(1);
        check("rst_mid_cnt", bus.cycle_cnt, 0);
        check("rst_mid_clk_out", bus.clk_out, IDLE_LEVEL);
        check("rst_mid_ticks", {bus.full_tick, bus.half_tick}, 0);
        check("rst_mid_cond", bus.cond_active, 0);
        reset = 1'b0;
        tick(1);
        check("restart_cnt", bus.cycle_cnt, 0);
        check("restart_clk_out", bus.clk_out, 1);
        check("restart_cond", bus.cond_active, 8);

        // enable falling on the boundary: stop wins, condition still loads
        bus.enable = 1'b0; bus.condition = 32'd2;
        tick(1);
        bus.enable = 1'b1;
        tick(2);
        check("c2_full_at_boundary", bus.full_tick, 1);
        bus.enable = 1'b0; bus.condition = 32'd3;
        tick(1);
        check("stop_at_boundary_running", bus.running, 0);
        check("stop_at_boundary_cond", bus.cond_active, 3);

`ifdef PTG_COND_ACK_EN
        bus.condition = 32'd4;
        tick(2);
        check("ack_unchanged", bus.cond_ack, 0);
        bus.condition = 32'd10;
        tick(1);
        check("ack_pulse", bus.cond_ack, 1);
        check("ack_cond", bus.cond_active, 10);
        tick(1);
        check("ack_single", bus.cond_ack, 0);
`endif

        // mixed vectors covered by the model only
        bus.enable = 1'b1; bus.condition = 32'd3;  tick(9);
        bus.condition = 32'd2;                     tick(5);
        bus.enable = 1'b0;                         tick(1);
        bus.enable = 1'b1; bus.condition = 32'd7;  tick(20);
        bus.condition = 32'h8000_0001;             tick(12);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
